// File: rtl/fht_seq_ctrl.sv
// Frame sequencer for fht_top: loads a streamed ADC frame into the four RAM banks, kicks the
// transform, then streams the result back out in bit-reversed row order.
module fht_seq_ctrl #(
    parameter int unsigned A_BIT     = 8,
    parameter int unsigned D_BIT     = 22,
    parameter int unsigned ADC_WIDTH = 16,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned TIMEOUT   = 65535
) (
    input  logic                 iCLK,
    input  logic                 iRESET,
    input  logic                 iGO,
    output logic                 oBUSY,
    output logic                 oERR,
    input  logic [ADC_WIDTH-1:0] iADC_DATA,
    input  logic                 iADC_VALID,
    output logic                 oADC_READY,
    output logic [3:0]           oWE,
    output logic [A_BIT-1:0]     oADDR_WR,
    output logic [D_BIT-1:0]     oDATA_WR,
    output logic                 oSTART,
    input  logic                 iRDY,
    output logic [A_BIT-1:0]     oADDR_RD,
    input  logic [D_BIT-1:0]     iDATA_RD_0,
    input  logic [D_BIT-1:0]     iDATA_RD_1,
    input  logic [D_BIT-1:0]     iDATA_RD_2,
    input  logic [D_BIT-1:0]     iDATA_RD_3,
    output logic [D_BIT-1:0]     oOUT_DATA,
    output logic                 oOUT_VALID,
    input  logic                 iOUT_READY,
    output logic                 oOUT_LAST
);

    typedef enum logic [2:0] {
        StIdle, StLoad, StStart, StWaitRdy, StRdAddr, StRdWait, StEmit
    } state_e;

    state_e               state_q, state_d;
    logic [A_BIT+1:0]     ld_cnt_q, ld_cnt_d;
    logic                 ld_full_q, ld_full_d;
    logic [3:0]           we_q, we_d;
    logic [A_BIT-1:0]     addr_wr_q, addr_wr_d;
    logic [D_BIT-1:0]     data_wr_q, data_wr_d;
    logic                 rdy_q, rdy_prev_q;
    logic [31:0]          tmo_cnt_q, tmo_cnt_d;
    logic [A_BIT-1:0]     row_cnt_q, row_cnt_d;
    logic [1:0]           lat_cnt_q, lat_cnt_d;
    logic [1:0]           word_cnt_q, word_cnt_d;
    logic [D_BIT-1:0]     rd_buf_q [4];
    logic [D_BIT-1:0]     rd_buf_d [4];
    logic                 err_q, err_d;

    logic                 accept;
    logic                 rdy_edge;
    logic                 last_row;

    assign accept   = (state_q == StLoad) && !ld_full_q && iADC_VALID;
    // The first WAIT_RDY cycle (tmo_cnt_q == 0) never counts, so a stale high ready is ignored.
    assign rdy_edge = (tmo_cnt_q != 32'd0) && rdy_q && !rdy_prev_q;
    assign last_row = &row_cnt_q;

    always_comb begin
        state_d    = state_q;
        ld_cnt_d   = ld_cnt_q;
        ld_full_d  = ld_full_q;
        we_d       = 4'b0000;
        addr_wr_d  = addr_wr_q;
        data_wr_d  = data_wr_q;
        tmo_cnt_d  = tmo_cnt_q;
        row_cnt_d  = row_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        word_cnt_d = word_cnt_q;
        rd_buf_d   = rd_buf_q;
        err_d      = err_q;
        unique case (state_q)
            StIdle: begin
                if (iGO) begin
                    state_d   = StLoad;
                    err_d     = 1'b0;
                    ld_cnt_d  = '0;
                    ld_full_d = 1'b0;
                    row_cnt_d = '0;
                end
            end
            StLoad: begin
                if (accept) begin
                    we_d      = 4'b0001 << ld_cnt_q[1:0];
                    addr_wr_d = ld_cnt_q[A_BIT+1:2];
                    data_wr_d = {iADC_DATA, {(D_BIT-ADC_WIDTH){1'b0}}};
                    ld_cnt_d  = ld_cnt_q + 1'b1;
                    if (&ld_cnt_q) ld_full_d = 1'b1;
                end else if (ld_full_q) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                state_d   = StWaitRdy;
                tmo_cnt_d = '0;
            end
            StWaitRdy: begin
                tmo_cnt_d = tmo_cnt_q + 32'd1;
                if (rdy_edge) begin
                    state_d   = StRdAddr;
                    row_cnt_d = '0;
                end else if (tmo_cnt_q == TIMEOUT - 1) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end
            end
            StRdAddr: begin
                state_d   = StRdWait;
                lat_cnt_d = '0;
            end
            StRdWait: begin
                lat_cnt_d = lat_cnt_q + 1'b1;
                if (lat_cnt_q == 2'(RD_LAT - 1)) begin
                    rd_buf_d[0] = iDATA_RD_0;
                    rd_buf_d[1] = iDATA_RD_1;
                    rd_buf_d[2] = iDATA_RD_2;
                    rd_buf_d[3] = iDATA_RD_3;
                    word_cnt_d  = '0;
                    state_d     = StEmit;
                end
            end
            StEmit: begin
                if (iOUT_READY) begin
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (word_cnt_q == 2'd3) begin
                        row_cnt_d = row_cnt_q + 1'b1;
                        state_d   = last_row ? StIdle : StRdAddr;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            ld_cnt_q   <= '0;
            ld_full_q  <= 1'b0;
            we_q       <= 4'b0000;
            addr_wr_q  <= '0;
            data_wr_q  <= '0;
            rdy_q      <= 1'b0;
            rdy_prev_q <= 1'b0;
            tmo_cnt_q  <= '0;
            row_cnt_q  <= '0;
            lat_cnt_q  <= '0;
            word_cnt_q <= '0;
            rd_buf_q   <= '{default: '0};
            err_q      <= 1'b0;
        end else begin
            ld_cnt_q   <= ld_cnt_d;
            ld_full_q  <= ld_full_d;
            we_q       <= we_d;
            addr_wr_q  <= addr_wr_d;
            data_wr_q  <= data_wr_d;
            rdy_q      <= iRDY;
            rdy_prev_q <= rdy_q;
            tmo_cnt_q  <= tmo_cnt_d;
            row_cnt_q  <= row_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
            word_cnt_q <= word_cnt_d;
            rd_buf_q   <= rd_buf_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        oADDR_RD = '0;
        for (int i = 0; i < int'(A_BIT); i++) begin
            oADDR_RD[i] = row_cnt_q[int'(A_BIT) - 1 - i];
        end
    end

    assign oBUSY      = (state_q != StIdle);
    assign oERR       = err_q;
    assign oADC_READY = (state_q == StLoad) && !ld_full_q;
    assign oWE        = we_q;
    assign oADDR_WR   = addr_wr_q;
    assign oDATA_WR   = data_wr_q;
    assign oSTART     = (state_q == StStart);
    assign oOUT_VALID = (state_q == StEmit);
    assign oOUT_DATA  = oOUT_VALID ? rd_buf_q[word_cnt_q] : '0;
    assign oOUT_LAST  = oOUT_VALID && (word_cnt_q == 2'd3) && last_row;

endmodule

// File: tb/tb_fht_seq_ctrl.sv
// Scoreboard bench for fht_seq_ctrl: a RAM model stores the loaded frame and the expected
// write and readout streams are queued at stimulus time, then checked by monitors.
module tb_fht_seq_ctrl;

    localparam int unsigned A_BIT = 3;
    localparam int unsigned D_BIT = 22;
    localparam int unsigned ADC_W = 16;
    localparam int unsigned SH    = D_BIT - ADC_W;
    localparam int          R     = 8;
    localparam int          N     = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             go = 0, go2 = 0, adc_valid = 0, rdy = 1, rdy2 = 1, out_ready = 1;
    logic [ADC_W-1:0] adc_data = '0;

    logic             busy, err, adc_ready, start, out_valid, out_last;
    logic [3:0]       we;
    logic [A_BIT-1:0] addr_wr, addr_rd;
    logic [D_BIT-1:0] data_wr, out_data;

    logic             busy2, err2, adc_ready2, start2, out_valid2, out_last2;
    logic [3:0]       we2;
    logic [A_BIT-1:0] addr_wr2, addr_rd2;
    logic [D_BIT-1:0] data_wr2, out_data2;

    logic [D_BIT-1:0] mem [4][R];
    logic [D_BIT-1:0] rd  [4];

    fht_seq_ctrl #(.A_BIT(A_BIT), .D_BIT(D_BIT), .ADC_WIDTH(ADC_W), .RD_LAT(1), .TIMEOUT(1000))
    dut (
        .iCLK(clk), .iRESET(rst_n), .iGO(go), .oBUSY(busy), .oERR(err),
        .iADC_DATA(adc_data), .iADC_VALID(adc_valid), .oADC_READY(adc_ready),
        .oWE(we), .oADDR_WR(addr_wr), .oDATA_WR(data_wr), .oSTART(start), .iRDY(rdy),
        .oADDR_RD(addr_rd), .iDATA_RD_0(rd[0]), .iDATA_RD_1(rd[1]), .iDATA_RD_2(rd[2]),
        .iDATA_RD_3(rd[3]), .oOUT_DATA(out_data), .oOUT_VALID(out_valid),
        .iOUT_READY(out_ready), .oOUT_LAST(out_last)
    );

    // Short-timeout instance used only for the stale-ready / timeout scenario.
    fht_seq_ctrl #(.A_BIT(A_BIT), .D_BIT(D_BIT), .ADC_WIDTH(ADC_W), .RD_LAT(1), .TIMEOUT(20))
    dut2 (
        .iCLK(clk), .iRESET(rst_n), .iGO(go2), .oBUSY(busy2), .oERR(err2),
        .iADC_DATA(adc_data), .iADC_VALID(adc_valid), .oADC_READY(adc_ready2),
        .oWE(we2), .oADDR_WR(addr_wr2), .oDATA_WR(data_wr2), .oSTART(start2), .iRDY(rdy2),
        .oADDR_RD(addr_rd2), .iDATA_RD_0(rd[0]), .iDATA_RD_1(rd[1]), .iDATA_RD_2(rd[2]),
        .iDATA_RD_3(rd[3]), .oOUT_DATA(out_data2), .oOUT_VALID(out_valid2),
        .iOUT_READY(out_ready), .oOUT_LAST(out_last2)
    );

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) mem[b][addr_wr] <= data_wr;
            rd[b] <= mem[b][addr_rd];
        end
    end

    int total = 0, bad = 0;
    int cyc = 0, last_we_cyc = -10, wr_cnt = 0, nwords = 0, nstart = 0, ov2_cnt = 0, w2_cnt = 0;
    int unsigned brev [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    logic [4+A_BIT+D_BIT-1:0] exp_wr [$];
    logic [D_BIT:0]           exp_out [$];
    logic [A_BIT-1:0]         exp_addr [$];
    logic [4+A_BIT+D_BIT-1:0] e_wr;
    logic [D_BIT:0]           e_out;
    logic [A_BIT-1:0]         e_addr;
    logic [D_BIT-1:0]         held;
    logic                     hold_chk = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: event not seen within bound (t=%0t)", name, $time);
    endtask

    function automatic logic [ADC_W-1:0] samp(input int pat, input int k);
        case (pat)
            0:       return ADC_W'(k);
            1:       return ADC_W'(-5 - 100 * k);
            default: return ADC_W'(1000 + 3 * k);
        endcase
    endfunction

    // Write monitor
    always @(negedge clk) begin
        if (rst_n && we != 4'b0000) begin
            if (exp_wr.size() == 0) begin
                fail("wr_unexpected");
            end else begin
                e_wr = exp_wr.pop_front();
                check("write", {we, addr_wr, data_wr}, e_wr);
            end
            wr_cnt++;
            last_we_cyc = cyc;
            if (wr_cnt == N) check("ready_low_after_last", adc_ready, 1'b0);
        end
        if (rst_n && we2 != 4'b0000) w2_cnt++;
    end

    // Start monitor
    always @(negedge clk) begin
        if (rst_n && start) begin
            nstart++;
            check("start_after_last_write", cyc, last_we_cyc + 1);
        end
    end

    // Output monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_chk) begin
                check("stall_valid_hold", out_valid, 1'b1);
                check("stall_data_hold", out_data, held);
            end
            hold_chk = 0;
            if (out_valid && !out_ready) begin
                hold_chk = 1;
                held = out_data;
            end
            if (out_valid && out_ready) begin
                if (nwords % 4 == 0) begin
                    if (exp_addr.size() == 0) fail("addr_unexpected");
                    else begin
                        e_addr = exp_addr.pop_front();
                        check("read_addr", addr_rd, e_addr);
                    end
                end
                if (exp_out.size() == 0) fail("out_unexpected");
                else begin
                    e_out = exp_out.pop_front();
                    check("out_word", {out_last, out_data}, e_out);
                end
                nwords++;
            end
            if (out_valid2) ov2_cnt++;
        end else begin
            hold_chk = 0;
        end
    end

    task automatic load_frame(input bit sel2, input int pat, input bit toggle, input bit go_mid);
        @(posedge clk); #1;
        if (sel2) go2 = 1; else go = 1;
        @(posedge clk); #1;
        go = 0;
        go2 = 0;
        for (int k = 0; k < N; k++) begin
            logic acc;
            int   g;
            if (toggle) begin
                adc_valid = 0;
                adc_data  = 16'hDEAD;
                @(posedge clk); #1;
            end
            adc_data  = samp(pat, k);
            adc_valid = 1;
            go        = go_mid && (k == 10);
            acc       = 0;
            g         = 0;
            while (!acc && g < 20) begin
                @(negedge clk);
                acc = sel2 ? adc_ready2 : adc_ready;
                if (acc && !sel2) exp_wr.push_back({4'(1 << (k % 4)), 3'(k / 4), samp(pat, k), SH'(0)});
                @(posedge clk); #1;
                go = 0;
                g++;
            end
            if (!acc) fail("load_accept");
        end
        adc_valid = 0;
    endtask

    task automatic run_frame(input int pat, input bit toggle, input bit go_mid, input bit stall,
                             input bit reset_mid);
        int g;
        int stall_left;
        wr_cnt = 0;
        nwords = 0;
        nstart = 0;
        for (int i = 0; i < R; i++) begin
            exp_addr.push_back(3'(brev[i]));
            for (int b = 0; b < 4; b++)
                exp_out.push_back({(i == R - 1 && b == 3), samp(pat, 4 * int'(brev[i]) + b), SH'(0)});
        end
        load_frame(0, pat, toggle, go_mid);
        g = 0;
        while (nstart == 0 && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        if (nstart == 0) fail("start_seen");
        rdy = 0;
        repeat (100) @(posedge clk);
        #1 rdy = 1;
        if (reset_mid) begin
            g = 0;
            while (nwords < 5 && g < 200) begin
                @(posedge clk); #1;
                g++;
            end
            check("in_emit_before_reset", out_valid, 1'b1);
            #1 rst_n = 0;
            #1;
            check("reset_busy", busy, 1'b0);
            check("reset_outputs", {busy, err, adc_ready, we, addr_wr, data_wr, start, addr_rd,
                                    out_data, out_valid, out_last}, 64'd0);
            exp_out.delete();
            exp_addr.delete();
            #4 rst_n = 1;
            @(posedge clk); #1;
            check("idle_after_reset", {busy, out_valid}, 2'b00);
            return;
        end
        stall_left = 10;
        g = 0;
        while (busy && g < 1000) begin
            if (stall && nwords == 6 && stall_left > 0) begin
                out_ready = 0;
                stall_left--;
            end else begin
                out_ready = 1;
            end
            @(posedge clk); #1;
            g++;
        end
        out_ready = 1;
        if (busy) fail("frame_done");
        check("start_count", nstart, 1);
        check("write_count", wr_cnt, N);
        check("word_count", nwords, N);
        check("out_queue_empty", exp_out.size(), 0);
        check("idle_after_frame", {busy, out_valid, err}, 3'b000);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs_init", {busy, err, adc_ready, we, addr_wr, data_wr, start, addr_rd,
                                     out_data, out_valid, out_last}, 64'd0);
        #3 rst_n = 1;

        // Plain load + readout, with an ignored iGO mid-load
        run_frame(0, 0, 1, 0, 0);
        // Toggling input valid (includes -5) and a 10-cycle output stall
        run_frame(1, 1, 0, 1, 0);

        // Stale-high ready on the short-timeout instance
        begin
            int g;
            int w0;
            w0 = w2_cnt;
            load_frame(1, 2, 0, 0);
            g = 0;
            while (!start2 && g < 50) begin
                @(negedge clk);
                g++;
            end
            if (!start2) fail("t5_start");
            repeat (20) @(negedge clk);
            check("t5_still_waiting", {busy2, err2}, 2'b10);
            @(negedge clk);
            check("t5_timed_out", {busy2, err2}, 2'b01);
            check("t5_no_readout", ov2_cnt, 0);
            check("t5_writes", w2_cnt - w0, N);
            @(posedge clk); #1 go2 = 1;
            @(posedge clk); #1 go2 = 0;
            @(negedge clk);
            check("t5_err_cleared", {busy2, err2}, 2'b10);
        end

        // Asynchronous reset in the middle of EMIT
        run_frame(2, 0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
